// File: rtl/filt_xfer_pkg.sv
// Shared encodings for the FFT/FIR file-transfer sequencer: FSM states,
// filter-select mode values and the per-state pause pair.
package filt_xfer_pkg;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] READ  = 3'd1;
    localparam logic [2:0] WRITE = 3'd2;
    localparam logic [2:0] HOLD  = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = IDLE,
        ST_READ  = READ,
        ST_WRITE = WRITE,
        ST_HOLD  = HOLD,
        ST_DONE  = DONE
    } state_t;

    localparam logic MODE_FFT = 1'b0;
    localparam logic MODE_FIR = 1'b1;

    // {read_pause, write_pause} for the selected filter; 2'b00 is unreachable.
    function automatic logic [1:0] pause_pair(input state_t s);
        case (s)
            ST_READ:  return 2'b01;
            ST_WRITE: return 2'b10;
            default:  return 2'b11;
        endcase
    endfunction

endpackage

// File: rtl/xfer_rd_delay.sv
// RAM read-latency model: delays the read strobe by RD_LAT cycles to form the
// accelerator input valid; flush drops every read still in flight.
module xfer_rd_delay #(
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic flush,
    input  logic in_vld,
    output logic out_vld,
    output logic pending
);

    logic [RD_LAT-1:0] vld_pipe;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe <= (vld_pipe << 1) | RD_LAT'(in_vld);
        end
    end

    assign out_vld = vld_pipe[RD_LAT-1];
    assign pending = |vld_pipe;

endmodule

// File: rtl/filt_xfer_sequencer.sv
// Runs one FFT or FIR file transfer through addr_calc_top, alternating read
// beats (RAM->accelerator) and write beats (accelerator->RAM) until done.
module filt_xfer_sequencer
    import filt_xfer_pkg::*;
#(
    parameter int RD_LAT  = 1,
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    input  logic             abort,
    input  logic             fft_read_done,
    input  logic             fft_write_done,
    input  logic             fir_read_done,
    input  logic             fir_write_done,
    input  logic             acc_in_ready,
    input  logic             acc_out_valid,
    output logic             fft_enable,
    output logic             fir_enable,
    output logic             fft_read_pause,
    output logic             fft_write_pause,
    output logic             fir_read_pause,
    output logic             fir_write_pause,
    output logic             ram_re,
    output logic             ram_we,
    output logic             acc_in_valid,
    output logic             acc_out_ready,
    output logic             busy,
    output logic             done_pulse,
    output logic             err_timeout,
    output logic [CNT_W-1:0] rd_beats,
    output logic [CNT_W-1:0] wr_beats
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    state_t          state;
    state_t          state_nx;
    logic            mode_q;
    logic            mode_nx;
    logic            start_acc;
    logic            abort_acc;
    logic            active;
    logic            rd_done;
    logic            wr_done;
    logic            pipe_pending;
    logic            pipe_empty;
    logic            run_nx;
    logic [1:0]      pp_nx;
    logic [1:0]      fft_pp_nx;
    logic [1:0]      fir_pp_nx;
    logic [WD_W-1:0] wd_cnt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign active     = (state == ST_HOLD) || (state == ST_READ) || (state == ST_WRITE);
    assign start_acc  = (state == ST_IDLE) && start;
    assign abort_acc  = active && abort;
    assign rd_done    = (mode_q == MODE_FIR) ? fir_read_done  : fft_read_done;
    assign wr_done    = (mode_q == MODE_FIR) ? fir_write_done : fft_write_done;
    // A read is in flight from the ram_re cycle until it leaves the latency pipe.
    assign pipe_empty = !ram_re && !pipe_pending;

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: begin
                if (start) state_nx = ST_HOLD;
            end
            ST_READ, ST_WRITE, ST_HOLD: begin
                if (abort)                                 state_nx = ST_IDLE;
                else if (rd_done && wr_done && pipe_empty) state_nx = ST_DONE;
                else if (acc_out_valid && !wr_done)        state_nx = ST_WRITE;
                else if (acc_in_ready && !rd_done && pipe_empty)
                                                           state_nx = ST_READ;
                else                                       state_nx = ST_HOLD;
            end
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        mode_nx   = start_acc ? mode : mode_q;
        run_nx    = (state_nx == ST_HOLD) || (state_nx == ST_READ) || (state_nx == ST_WRITE);
        pp_nx     = pause_pair(state_nx);
        fft_pp_nx = (mode_nx == MODE_FFT) ? pp_nx : 2'b11;
        fir_pp_nx = (mode_nx == MODE_FIR) ? pp_nx : 2'b11;
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= ST_IDLE;
            mode_q          <= MODE_FFT;
            fft_enable      <= 1'b0;
            fir_enable      <= 1'b0;
            fft_read_pause  <= 1'b1;
            fft_write_pause <= 1'b1;
            fir_read_pause  <= 1'b1;
            fir_write_pause <= 1'b1;
            ram_re          <= 1'b0;
            ram_we          <= 1'b0;
            acc_out_ready   <= 1'b0;
            busy            <= 1'b0;
            done_pulse      <= 1'b0;
            err_timeout     <= 1'b0;
            rd_beats        <= '0;
            wr_beats        <= '0;
            wd_cnt          <= '0;
        end else begin
            state                              <= state_nx;
            mode_q                             <= mode_nx;
            fft_enable                         <= run_nx && (mode_nx == MODE_FFT);
            fir_enable                         <= run_nx && (mode_nx == MODE_FIR);
            {fft_read_pause, fft_write_pause}  <= fft_pp_nx;
            {fir_read_pause, fir_write_pause}  <= fir_pp_nx;
            ram_re                             <= (state_nx == ST_READ);
            ram_we                             <= (state_nx == ST_WRITE);
            acc_out_ready                      <= (state_nx == ST_WRITE);
            busy                               <= run_nx;
            done_pulse                         <= (state_nx == ST_DONE);

            if (start_acc) begin
                rd_beats <= '0;
                wr_beats <= '0;
            end else begin
                if (state_nx == ST_READ)  rd_beats <= sat_inc(rd_beats);
                if (state_nx == ST_WRITE) wr_beats <= sat_inc(wr_beats);
            end

            // Watchdog only flags a stall; the FSM keeps waiting in HOLD.
            if (state == ST_HOLD) begin
                if (wd_cnt == WD_W'(TIMEOUT - 1)) err_timeout <= 1'b1;
                else                              wd_cnt      <= wd_cnt + 1'b1;
            end else begin
                wd_cnt <= '0;
            end
            if (start_acc) err_timeout <= 1'b0;
        end
    end

    xfer_rd_delay #(
        .RD_LAT (RD_LAT)
    ) u_rd_delay (
        .clk     (clk),
        .reset   (reset),
        .flush   (start_acc || abort_acc),
        .in_vld  (ram_re),
        .out_vld (acc_in_valid),
        .pending (pipe_pending)
    );

endmodule

// File: tb/tb_filt_xfer_sequencer.sv
// Directed bench for filt_xfer_sequencer with a small address-calculator and
// accelerator model; table-driven full runs plus hand-written corner cases.
`timescale 1ns/1ps
module tb_filt_xfer_sequencer;
    import filt_xfer_pkg::*;

    localparam int RD_LAT  = 3;
    localparam int TIMEOUT = 1024;
    localparam int CNT_W   = 32;
    localparam int FS      = 8;
    localparam logic [12:0] IDLE_O = 13'b0011110000000;
    localparam logic [12:0] DONE_O = 13'b0011110000010;

    logic clk = 1'b0;
    logic reset, start, mode, abort;
    logic fft_read_done, fft_write_done, fir_read_done, fir_write_done;
    logic acc_in_ready, acc_out_valid;
    logic fft_enable, fir_enable;
    logic fft_read_pause, fft_write_pause, fir_read_pause, fir_write_pause;
    logic ram_re, ram_we, acc_in_valid, acc_out_ready, busy, done_pulse, err_timeout;
    logic [CNT_W-1:0] rd_beats, wr_beats;

    int n_cmp = 0;
    int n_bad = 0;
    int ov_mode = 2;
    logic calc_clr;
    int fft_rc, fft_wc, fir_rc, fir_wc;

    typedef struct {
        logic m;
        bit   ir;
        int   ovm;
        int   exp_cyc;
        int   exp_rd;
        int   exp_wr;
        bit   exp_early;
    } vec_t;
    vec_t vecs[4];

    always #5 clk = ~clk;

    filt_xfer_sequencer #(
        .RD_LAT(RD_LAT), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .abort(abort),
        .fft_read_done(fft_read_done), .fft_write_done(fft_write_done),
        .fir_read_done(fir_read_done), .fir_write_done(fir_write_done),
        .acc_in_ready(acc_in_ready), .acc_out_valid(acc_out_valid),
        .fft_enable(fft_enable), .fir_enable(fir_enable),
        .fft_read_pause(fft_read_pause), .fft_write_pause(fft_write_pause),
        .fir_read_pause(fir_read_pause), .fir_write_pause(fir_write_pause),
        .ram_re(ram_re), .ram_we(ram_we), .acc_in_valid(acc_in_valid),
        .acc_out_ready(acc_out_ready), .busy(busy), .done_pulse(done_pulse),
        .err_timeout(err_timeout), .rd_beats(rd_beats), .wr_beats(wr_beats)
    );

    // Address calculator: advances one word per unpaused enabled cycle, done is sticky.
    always @(posedge clk) begin
        if (calc_clr) begin
            fft_rc <= 0; fft_wc <= 0; fir_rc <= 0; fir_wc <= 0;
        end else begin
            if (fft_enable && !fft_read_pause  && fft_rc < FS) fft_rc <= fft_rc + 1;
            if (fft_enable && !fft_write_pause && fft_wc < FS) fft_wc <= fft_wc + 1;
            if (fir_enable && !fir_read_pause  && fir_rc < FS) fir_rc <= fir_rc + 1;
            if (fir_enable && !fir_write_pause && fir_wc < FS) fir_wc <= fir_wc + 1;
        end
    end
    assign fft_read_done  = (fft_rc >= FS);
    assign fft_write_done = (fft_wc >= FS);
    assign fir_read_done  = (fir_rc >= FS);
    assign fir_write_done = (fir_wc >= FS);

    // ov_mode: 0 = result echoes acc_in_valid, 1 = always valid, 2 = never valid.
    assign acc_out_valid = (ov_mode == 1) || ((ov_mode == 0) && acc_in_valid);

    function automatic logic [12:0] outs();
        return {fft_enable, fir_enable, fft_read_pause, fft_write_pause,
                fir_read_pause, fir_write_pause, ram_re, ram_we, acc_in_valid,
                acc_out_ready, busy, done_pulse, err_timeout};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic kick(input logic m, input bit ir, input int ovm);
        mode = m; acc_in_ready = ir; ov_mode = ovm; start = 1'b1; calc_clr = 1'b1;
        @(negedge clk);
        start = 1'b0; calc_clr = 1'b0;
    endtask

    task automatic run_to_done(input logic m, input int k0, output int cyc,
                               output int bad_pause, output int bad_en, output bit early);
        cyc = 0; bad_pause = 0; bad_en = 0; early = 1'b0;
        for (int k = k0; k < k0 + 3000; k++) begin
            if ((!fft_read_pause && !fft_write_pause) || (!fir_read_pause && !fir_write_pause))
                bad_pause++;
            if ((m == MODE_FFT) ? fir_enable : fft_enable) bad_en++;
            if (ram_re && (wr_beats < 32'(FS))) early = 1'b1;
            if (done_pulse) begin
                cyc = k;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  cyc, bp, be, cnt;
        bit  early, found;

        // Hand-computed with RD_LAT=3: echo runs pair every 5 cycles; with result
        // always valid, writes run back-to-back and the done flag lags one beat.
        vecs[0] = '{MODE_FFT, 1'b1, 0, 43, 8, 8, 1'b1};
        vecs[1] = '{MODE_FIR, 1'b1, 0, 43, 8, 8, 1'b1};
        vecs[2] = '{MODE_FIR, 1'b1, 1, 51, 8, 9, 1'b0};
        vecs[3] = '{MODE_FFT, 1'b1, 1, 51, 8, 9, 1'b0};

        reset = 1'b1; start = 1'b0; mode = MODE_FFT; abort = 1'b0;
        acc_in_ready = 1'b0; calc_clr = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", outs(), IDLE_O);
        chk("reset_rd_beats", rd_beats, 0);
        chk("reset_wr_beats", wr_beats, 0);
        reset = 1'b0; calc_clr = 1'b0;
        @(negedge clk);
        chk("idle_outs", outs(), IDLE_O);

        for (int i = 0; i < 4; i++) begin
            kick(vecs[i].m, vecs[i].ir, vecs[i].ovm);
            chk($sformatf("row%0d_busy", i), busy, 1);
            run_to_done(vecs[i].m, 1, cyc, bp, be, early);
            chk($sformatf("row%0d_cycles", i), cyc, vecs[i].exp_cyc);
            chk($sformatf("row%0d_rd_beats", i), rd_beats, vecs[i].exp_rd);
            chk($sformatf("row%0d_wr_beats", i), wr_beats, vecs[i].exp_wr);
            chk($sformatf("row%0d_done_outs", i), outs(), DONE_O);
            chk($sformatf("row%0d_pause00", i), bp, 0);
            chk($sformatf("row%0d_wrong_enable", i), be, 0);
            chk($sformatf("row%0d_read_before_writes", i), early, vecs[i].exp_early);
            @(negedge clk);
            chk($sformatf("row%0d_after_outs", i), outs(), IDLE_O);
        end

        // Watchdog: stall from the first HOLD cycle.
        kick(MODE_FFT, 1'b0, 2);
        repeat (1023) @(negedge clk);
        chk("wd_err_at_1024", err_timeout, 0);
        @(negedge clk);
        chk("wd_err_at_1025", err_timeout, 1);
        chk("wd_still_hold", {busy, ram_re, ram_we}, 3'b100);
        acc_in_ready = 1'b1; ov_mode = 0;
        @(negedge clk);
        chk("wd_read_resumes", {ram_re, err_timeout}, 2'b11);
        run_to_done(MODE_FFT, 1026, cyc, bp, be, early);
        chk("wd_run_cycles", cyc, 1067);
        chk("wd_done_outs", outs(), DONE_O | 13'd1);
        @(negedge clk);
        chk("wd_err_sticky", outs(), IDLE_O | 13'd1);

        // Abort during READ.
        kick(MODE_FFT, 1'b1, 0);
        chk("ab_start_clears_err", {busy, fft_enable, err_timeout}, 3'b110);
        @(negedge clk);
        chk("ab_in_read", ram_re, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("ab_outs", outs(), IDLE_O);
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (acc_in_valid || done_pulse || busy) cnt++;
        end
        chk("ab_no_late_activity", cnt, 0);

        // Start while busy, then reset on read beat 5.
        kick(MODE_FIR, 1'b1, 0);
        repeat (3) @(negedge clk);
        start = 1'b1; mode = MODE_FFT;
        @(negedge clk);
        start = 1'b0;
        chk("sb_enables", {fft_enable, fir_enable, busy}, 3'b011);
        chk("sb_rd_beats", rd_beats, 1);
        found = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (rd_beats == 32'd5) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("sb_beat5_seen", {found, ram_re}, 2'b11);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rs_outs", outs(), IDLE_O);
        chk("rs_rd_beats", rd_beats, 0);
        chk("rs_wr_beats", wr_beats, 0);
        cnt = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (acc_in_valid || busy) cnt++;
        end
        chk("rs_inflight_dropped", cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
